mc_control: RTL
===============

Name: mc_control

Overview:
- Multicycle main control FSM for the single-issue MIPS-subset datapath.
- Decodes the IR opcode/funct and sequences fetch, decode, execute, memory and writeback.
- Drives the 2-bit ALU operation select (00 add, 01 sub, 10 or, 11 and) and all datapath enables.
- Consumes the ALU zero and overflow flags for branch resolution and overflow exceptions.

Parameters:
- EXC_VEC_SEL, 2'b11, pc_src code that selects the exception vector.
- ILLEGAL_TRAP, 1, 1 = unknown opcode/funct enters EXCEPT; 0 = treated as NOP (back to FETCH).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- opcode  in  6  IR[31:26], valid from DECODE onward.
- funct  in  6  IR[5:0].
- zero  in  1  ALU zero flag (combinational from the current ALU inputs).
- over  in  1  ALU overflow flag (combinational).
- pc_write  out  1  PC load enable (already includes branch-taken qualification).
- pc_src  out  2  00 ALU result, 01 ALUOut, 10 jump target, 11 exception vector.
- ir_write  out  1  IR load.
- iord  out  1  memory address select: 0 PC, 1 ALUOut.
- mem_read  out  1  memory read strobe.
- mem_write  out  1  memory write strobe.
- mem_to_reg  out  1  writeback data select: 1 MDR, 0 ALUOut.
- reg_write  out  1  register file write enable.
- reg_dst  out  1  destination select: 1 rd, 0 rt.
- alu_src_a  out  1  0 PC, 1 regA.
- alu_src_b  out  2  00 regB, 01 const 4, 10 sign-extended imm, 11 sign-extended imm<<2.
- aluc  out  2  ALU operation select.
- exc  out  1  one-cycle exception pulse.
- exc_cause  out  2  00 none, 01 overflow, 10 illegal instruction; registered.

Behaviour:
- State register is 4-bit and encoded in the shared package. Reset forces state FETCH and exc_cause = 00.
- While rst is high, all outputs = 0 except the FETCH decode below. Reset mid-instruction aborts it; no write strobe may assert in the reset cycle.
- Outputs are Moore decodes of state. The only exception is pc_write in BRANCH, which follows zero. Any output not listed for a state is 0.
- FETCH:
  - mem_read=1, iord=0, ir_write=1, alu_src_a=0, alu_src_b=01, aluc=00, pc_src=00, pc_write=1.
  - Next state: DECODE.
- DECODE:
  - alu_src_a=0, alu_src_b=11, aluc=00 (branch target into ALUOut).
  - lw/sw (100011/101011) -> MEM_ADDR.
  - R-type (000000) with funct add 100000, sub 100010, or 100101, and 100100 -> EXEC_R.
  - addi 001000 / ori 001101 -> EXEC_I.
  - beq 000100 -> BRANCH.
  - j 000010 -> JUMP.
  - Anything else -> EXCEPT if ILLEGAL_TRAP, else FETCH.
- MEM_ADDR: alu_src_a=1, alu_src_b=10, aluc=00. Next state: MEM_RD for lw, MEM_WR for sw.
- MEM_RD: mem_read=1, iord=1. Next state: MEM_WB.
- MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0. Next state: FETCH.
- MEM_WR: mem_write=1, iord=1. Next state: FETCH.
- EXEC_R:
  - alu_src_a=1, alu_src_b=00; aluc from funct: add 00, sub 01, or 10, and 11.
  - If over=1 and funct is add/sub -> EXCEPT; else -> WB_R.
- WB_R: reg_write=1, reg_dst=1, mem_to_reg=0. Next state: FETCH.
- EXEC_I:
  - alu_src_a=1, alu_src_b=10; aluc = 00 for addi, 10 for ori.
  - If over=1 and addi -> EXCEPT; else -> WB_I. over is ignored for ori.
- WB_I: reg_write=1, reg_dst=0. Next state: FETCH.
- BRANCH:
  - alu_src_a=1, alu_src_b=00, aluc=01, pc_src=01, pc_write=zero.
  - Next state: FETCH. Not-taken is 3 cycles total, the same as taken.
- JUMP: pc_src=10, pc_write=1. Next state: FETCH.
- EXCEPT:
  - exc=1, pc_src=EXC_VEC_SEL, pc_write=1, no register or memory write.
  - exc_cause latched on entry (01 overflow, 10 illegal) and held until the next exception or reset.
  - Next state: FETCH.
- Latencies (cycles, FETCH inclusive):
  - lw 5.
  - sw, R-type, I-type 4.
  - beq, j 3.
  - Overflow path 4 (FETCH, DECODE, EXEC, EXCEPT).
- Illegal opcode path 3 cycles. An overflowing instruction never asserts reg_write.
- Unreachable state encodings -> FETCH.

Decomposition:
- Package mc_pkg holds:
  - state enum/localparams;
  - opcode and funct constants;
  - aluc codes (ALU_ADD 00, ALU_SUB 01, ALU_OR 10, ALU_AND 11);
  - pc_src and alu_src_b codes;
  - exc_cause codes.
- One sub-module, mc_alu_dec: combinational map of (state class, opcode, funct) to aluc plus an is_arith flag (add/sub/addi) used for the overflow gate.

Test Plan:
- Reset: assert rst mid-MEM_WR -> same-cycle mem_write=0, state FETCH, exc_cause=00; on release, first cycle has ir_write=1, pc_write=1.
- lw (opcode 100011): 5 cycles; mem_read high in FETCH and MEM_RD; reg_write=1, mem_to_reg=1 only in cycle 5.
- R-type add with over=1 held in EXEC_R -> exc=1 in cycle 4, exc_cause=01, reg_write never 1. Same stimulus with funct 100101 (or) -> WB_R, reg_write=1, reg_dst=1.
- beq: zero=1 -> pc_write=1, pc_src=01 in cycle 3; zero=0 -> pc_write=0; both return to FETCH in cycle 4.
- Illegal instructions, ILLEGAL_TRAP=1: opcode 111111 -> EXCEPT in cycle 3, exc_cause=10, pc_src=11. R-type funct 000111 -> same response.
- ori with over=1 -> no exception; aluc=10 in EXEC_I; reg_write=1 in WB_I. j -> pc_src=10, pc_write=1 in cycle 3.

Source files
------------

// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle main control FSM:
// states, opcodes, functs and datapath select codes.
package mc_pkg;

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEM_ADDR = 4'd2;
  localparam logic [3:0] S_MEM_RD   = 4'd3;
  localparam logic [3:0] S_MEM_WB   = 4'd4;
  localparam logic [3:0] S_MEM_WR   = 4'd5;
  localparam logic [3:0] S_EXEC_R   = 4'd6;
  localparam logic [3:0] S_WB_R     = 4'd7;
  localparam logic [3:0] S_EXEC_I   = 4'd8;
  localparam logic [3:0] S_WB_I     = 4'd9;
  localparam logic [3:0] S_BRANCH   = 4'd10;
  localparam logic [3:0] S_JUMP     = 4'd11;
  localparam logic [3:0] S_EXCEPT   = 4'd12;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_AND = 6'b100100;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_OR  = 2'b10;
  localparam logic [1:0] ALU_AND = 2'b11;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;
  localparam logic [1:0] PC_EXC    = 2'b11;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_BR   = 2'b11;

  localparam logic [1:0] EXC_NONE = 2'b00;
  localparam logic [1:0] EXC_OVF  = 2'b01;
  localparam logic [1:0] EXC_ILL  = 2'b10;

  typedef enum logic [1:0] {
    ACLS_ADD,
    ACLS_SUB,
    ACLS_R,
    ACLS_I
  } alu_cls_e;

  function automatic logic is_rfunct(
    input logic [5:0] fn
  );
    return (fn == FN_ADD) || (fn == FN_SUB) ||
           (fn == FN_OR)  || (fn == FN_AND);
  endfunction

endpackage

// File: rtl/mc_if.sv
// Control/datapath bundle: IR fields and ALU flags in,
// datapath enables and selects out.
interface mc_if;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       over;
  logic       pc_write;
  logic [1:0] pc_src;
  logic       ir_write;
  logic       iord;
  logic       mem_read;
  logic       mem_write;
  logic       mem_to_reg;
  logic       reg_write;
  logic       reg_dst;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] aluc;
  logic       exc;
  logic [1:0] exc_cause;

  modport master (
    input  opcode, funct, zero, over,
    output pc_write, pc_src, ir_write, iord,
    output mem_read, mem_write, mem_to_reg,
    output reg_write, reg_dst, alu_src_a,
    output alu_src_b, aluc, exc, exc_cause
  );

  modport slave (
    output opcode, funct, zero, over,
    input  pc_write, pc_src, ir_write, iord,
    input  mem_read, mem_write, mem_to_reg,
    input  reg_write, reg_dst, alu_src_a,
    input  alu_src_b, aluc, exc, exc_cause
  );
endinterface

// File: rtl/mc_alu_dec.sv
// ALU operation decode; is_arith marks the trapping
// arithmetic ops (add, sub, addi).
module mc_alu_dec
  import mc_pkg::*;
(
  input  alu_cls_e   cls,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output logic [1:0] aluc,
  output logic       is_arith
);

  always_comb begin
    aluc     = ALU_ADD;
    is_arith = 1'b0;
    unique case (cls)
      ACLS_ADD: aluc = ALU_ADD;
      ACLS_SUB: aluc = ALU_SUB;
      ACLS_R: begin
        case (funct)
          FN_SUB:  aluc = ALU_SUB;
          FN_OR:   aluc = ALU_OR;
          FN_AND:  aluc = ALU_AND;
          default: aluc = ALU_ADD;
        endcase
        is_arith = (funct == FN_ADD) ||
                   (funct == FN_SUB);
      end
      ACLS_I: begin
        aluc     = (opcode == OP_ORI) ?
                   ALU_OR : ALU_ADD;
        is_arith = (opcode == OP_ADDI);
      end
      default: aluc = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mc_control.sv
// Multicycle main control FSM: sequences fetch through
// writeback and raises overflow/illegal exceptions.
module mc_control
  import mc_pkg::*;
#(
  parameter logic [1:0] EXC_VEC_SEL  = 2'b11,
  parameter bit         ILLEGAL_TRAP = 1'b1
) (
  input logic clk,
  input logic rst,
  mc_if.master bus
);

  logic [3:0] state;
  logic [3:0] state_nx;
  logic [1:0] cause_q;
  logic [1:0] cause_nx;
  alu_cls_e   cls;
  logic [1:0] dec_aluc;
  logic       is_arith;

  always_comb begin
    cls = ACLS_ADD;
    case (state)
      S_EXEC_R: cls = ACLS_R;
      S_EXEC_I: cls = ACLS_I;
      S_BRANCH: cls = ACLS_SUB;
      default:  cls = ACLS_ADD;
    endcase
  end

  mc_alu_dec u_alu_dec (
    .cls      (cls),
    .opcode   (bus.opcode),
    .funct    (bus.funct),
    .aluc     (dec_aluc),
    .is_arith (is_arith)
  );

  always_comb begin
    state_nx = S_FETCH;
    cause_nx = cause_q;
    case (state)
      S_FETCH: state_nx = S_DECODE;
      S_DECODE: begin
        unique case (1'b1)
          (bus.opcode == OP_LW) ||
          (bus.opcode == OP_SW):
            state_nx = S_MEM_ADDR;
          (bus.opcode == OP_RTYPE) &&
          is_rfunct(bus.funct):
            state_nx = S_EXEC_R;
          (bus.opcode == OP_ADDI) ||
          (bus.opcode == OP_ORI):
            state_nx = S_EXEC_I;
          (bus.opcode == OP_BEQ):
            state_nx = S_BRANCH;
          (bus.opcode == OP_J):
            state_nx = S_JUMP;
          default: begin
            if (ILLEGAL_TRAP) begin
              state_nx = S_EXCEPT;
              cause_nx = EXC_ILL;
            end
          end
        endcase
      end
      S_MEM_ADDR:
        state_nx = (bus.opcode == OP_SW) ?
                   S_MEM_WR : S_MEM_RD;
      S_MEM_RD: state_nx = S_MEM_WB;
      S_EXEC_R, S_EXEC_I: begin
        // Only add/sub/addi trap; logical ops ignore over.
        if (bus.over && is_arith) begin
          state_nx = S_EXCEPT;
          cause_nx = EXC_OVF;
        end else begin
          state_nx = (state == S_EXEC_R) ?
                     S_WB_R : S_WB_I;
        end
      end
      default: state_nx = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_FETCH;
      cause_q <= EXC_NONE;
    end else begin
      state   <= state_nx;
      cause_q <= cause_nx;
    end
  end

  assign bus.exc_cause = cause_q;
  assign bus.aluc      = dec_aluc;

  always_comb begin
    bus.pc_write   = 1'b0;
    bus.pc_src     = PC_ALU;
    bus.ir_write   = 1'b0;
    bus.iord       = 1'b0;
    bus.mem_read   = 1'b0;
    bus.mem_write  = 1'b0;
    bus.mem_to_reg = 1'b0;
    bus.reg_write  = 1'b0;
    bus.reg_dst    = 1'b0;
    bus.alu_src_a  = 1'b0;
    bus.alu_src_b  = SRCB_REG;
    bus.exc        = 1'b0;
    case (state)
      S_FETCH: begin
        bus.mem_read  = 1'b1;
        bus.ir_write  = 1'b1;
        bus.alu_src_b = SRCB_FOUR;
        bus.pc_write  = 1'b1;
      end
      S_DECODE: bus.alu_src_b = SRCB_BR;
      S_MEM_ADDR: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = SRCB_IMM;
      end
      S_MEM_RD: begin
        bus.mem_read = 1'b1;
        bus.iord     = 1'b1;
      end
      S_MEM_WB: begin
        bus.reg_write  = 1'b1;
        bus.mem_to_reg = 1'b1;
      end
      S_MEM_WR: begin
        bus.mem_write = 1'b1;
        bus.iord      = 1'b1;
      end
      S_EXEC_R: bus.alu_src_a = 1'b1;
      S_WB_R: begin
        bus.reg_write = 1'b1;
        bus.reg_dst   = 1'b1;
      end
      S_EXEC_I: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = SRCB_IMM;
      end
      S_WB_I: bus.reg_write = 1'b1;
      S_BRANCH: begin
        bus.alu_src_a = 1'b1;
        bus.pc_src    = PC_ALUOUT;
        bus.pc_write  = bus.zero;
      end
      S_JUMP: begin
        bus.pc_src   = PC_JUMP;
        bus.pc_write = 1'b1;
      end
      S_EXCEPT: begin
        bus.exc      = 1'b1;
        bus.pc_src   = EXC_VEC_SEL;
        bus.pc_write = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
